tawas_rcn_slave: RTL and testbench
==================================

# tawas_rcn_slave

Responder end of the 69-bit rcn ring used by the tawas core's bus masters. Sits as one registered hop on the ring. Removes request packets whose address falls in its window and issues them to a local register/memory port. Returns in-order response packets addressed to the originating master id / sequence.

## Interface
Parameters:
- ADDR_BASE, 24'h000000, byte base address of window
- ADDR_MASK, 24'hFF0000, address bits compared against ADDR_BASE (bits [1:0] ignored)
- DEPTH, 4, response queue entries (power of two, 2..16)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; **synchronous, active-high**
- rcn_in  in  69  ring input
- rcn_out  out  69  ring output, registered
- cs  out  1  one-cycle local request strobe
- wr  out  1  local write (1) / read (0)
- mask  out  4  byte enables
- addr  out  24  byte address, [1:0]=0
- wdata  out  32  write data
- rvalid  in  1  local completion, one per cs, in issue order
- rdata  in  32  read data, valid with rvalid

## Operation
Packet fields: [68] valid, [67] request(1)/response(0), [66] wr, [65:63] master id, [62:60] seq[4:2], [59:56] mask, [55:34] addr[23:2], [33:32] seq[1:0], [31:0] data.
- rin: input register, loaded from rcn_in every cycle.
- hit = rin[68] & rin[67] & ((rin[55:34] ^ ADDR_BASE[23:2]) & ADDR_MASK[23:2]) == 0.
- used = queue entries allocated, 0..DEPTH. accept = hit & (used < DEPTH).
- On accept: allocate tail entry, store header (wr, id, seq, mask, addr), wdata as data; mark entry pending; load cs/wr/mask/addr/wdata output registers, cs=1 next cycle.
- Hit with used==DEPTH: packet forwarded unchanged (circulates, retries next pass).
- rvalid: oldest pending entry marked done; read entries take rdata, write entries keep wdata. rvalid with no pending entry ignored.
- free = !rin[68] | accept.
- insert = free & head done. Response = {1,0,wr,id,seq[4:2],mask,addr[23:2],seq[1:0],data}. Head freed.
- rout next = insert ? response : accept ? 69'd0 : rin.
- Accept and insert in same cycle allowed; used updates by +1, -1 or 0.

## Timing
- Reset values: rcn_out=0, cs=0, wr=0, mask=0, addr=0, wdata=0; queue empty, used=0.
- Ring hop latency: 1 cycle rcn_in -> rin, 1 cycle rin -> rcn_out.
- cs asserted exactly 1 cycle after accepting rin cycle; never two consecutive cs from one accept.
- Minimum: rvalid in cycle N with head done and free slot -> response on rcn_out at N+2 (done flag registered at N+1, inserted into rout at N+2 edge).
- Busy ring: response waits indefinitely for free slot; no starvation of the ring beyond queue full.
- Reset mid-operation: all entries dropped, rcn_out cleared next edge; outstanding local rvalid after reset ignored.

## Configuration
- TAWAS_RCN_SLAVE_WR_POSTED_EN defined: write entries marked done at accept; no cs-to-rvalid pairing for writes; local asserts rvalid only for reads. Write response still ordered behind older pending reads.
- Undefined: every cs, read or write, requires exactly one rvalid; write entry done on that rvalid.

## Test plan
- Read: request id 3, seq 5'h0B, addr 24'h000010 in window, rdata 32'hCAFE_F00D with rvalid 2 cycles after cs -> one response, [67]=0, [66]=0, id 3, seq 5'h0B, data 32'hCAFE_F00D.
- Write (macro off): wdata 32'h1234_5678 mask 4'h3 -> cs,wr=1, mask 3; after rvalid response [66]=1 data 32'h1234_5678; macro on -> response without rvalid.
- Out of window: addr 24'h010000 with base 0, mask FF0000 -> rcn_out equals input delayed 2 cycles; cs stays 0.
- Queue full: DEPTH=4, rvalid held low, 5 back-to-back requests -> 4 cs, fifth passes through unchanged; after rvalids, 4 ordered responses.
- Busy ring: continuous foreign valid packets while head done -> no insertion; first empty slot -> response inserted that cycle's rout.
- Reset mid-flight: rst for 1 cycle with 2 entries pending -> rcn_out=0, cs=0 next cycle; late rvalids produce no response.

Source files
------------

// File: rtl/tawas_rcn_slave_if.sv
// Bundle of rcn ring and local bus signals for tawas_rcn_slave.
// Ring hop plus request/completion port toward a local register/memory block.
interface tawas_rcn_slave_if;
    logic [68:0] rcn_in;
    logic [68:0] rcn_out;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport slave (
        input  rcn_in, rvalid, rdata,
        output rcn_out, cs, wr, mask, addr, wdata
    );

    modport master (
        output rcn_in, rvalid, rdata,
        input  rcn_out, cs, wr, mask, addr, wdata
    );
endinterface

// File: rtl/tawas_rcn_slave.sv
// rcn ring responder: claims windowed requests, returns ordered responses.
// Define TAWAS_RCN_SLAVE_WR_POSTED_EN to complete writes at accept.
module tawas_rcn_slave #(
    parameter logic [23:0] ADDR_BASE = 24'h000000,
    parameter logic [23:0] ADDR_MASK = 24'hFF0000,
    parameter int          DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    tawas_rcn_slave_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;

    logic [68:0]      rin_q;
    logic [68:0]      rout_q;
    logic [68:0]      ent_q [DEPTH];
    logic [DEPTH-1:0] done_q;
    ptr_t             head_q;
    ptr_t             tail_q;
    logic [PW:0]      used_q;
    logic             cs_q;
    logic             wr_q;
    logic [3:0]       mask_q;
    logic [23:0]      addr_q;
    logic [31:0]      wdata_q;

    logic hit;
    logic accept;
    logic free;
    logic insert;
    logic acc_done;
    logic pend_vld;
    ptr_t pend_idx;

    assign hit = rin_q[68] & rin_q[67] &
                 (((rin_q[55:34] ^ ADDR_BASE[23:2]) & ADDR_MASK[23:2]) == '0);
    assign accept = hit & (used_q < (PW+1)'(DEPTH));
    assign free   = ~rin_q[68] | accept;
    assign insert = free & (used_q != '0) & done_q[head_q];

`ifdef TAWAS_RCN_SLAVE_WR_POSTED_EN
    assign acc_done = rin_q[66];
`else
    assign acc_done = 1'b0;
`endif

    // Oldest allocated entry still waiting for its local completion.
    always_comb begin
        pend_vld = 1'b0;
        pend_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!pend_vld && (i < int'(used_q)) &&
                !done_q[head_q + ptr_t'(i)]) begin
                pend_vld = 1'b1;
                pend_idx = head_q + ptr_t'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rin_q   <= '0;
            rout_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            used_q  <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            rin_q  <= bus.rcn_in;
            rout_q <= insert ? ent_q[head_q] : (accept ? '0 : rin_q);
            cs_q   <= accept;
            if (accept) begin
                ent_q[tail_q]  <= {1'b1, 1'b0, rin_q[66:0]};
                done_q[tail_q] <= acc_done;
                tail_q         <= tail_q + ptr_t'(1);
                wr_q           <= rin_q[66];
                mask_q         <= rin_q[59:56];
                addr_q         <= {rin_q[55:34], 2'b00};
                wdata_q        <= rin_q[31:0];
            end
            if (bus.rvalid && pend_vld) begin
                done_q[pend_idx] <= 1'b1;
                if (!ent_q[pend_idx][66]) begin
                    ent_q[pend_idx][31:0] <= bus.rdata;
                end
            end
            if (insert) begin
                done_q[head_q] <= 1'b0;
                head_q         <= head_q + ptr_t'(1);
            end
            unique case ({accept, insert})
                2'b10:   used_q <= used_q + 1'b1;
                2'b01:   used_q <= used_q - 1'b1;
                default: used_q <= used_q;
            endcase
        end
    end

    assign bus.rcn_out = rout_q;
    assign bus.cs      = cs_q;
    assign bus.wr      = wr_q;
    assign bus.mask    = mask_q;
    assign bus.addr    = addr_q;
    assign bus.wdata   = wdata_q;
endmodule

// File: tb/tb_tawas_rcn_slave.sv
// Bench for tawas_rcn_slave: directed ring scenarios plus random traffic
// checked against a transaction-level model of expected responses.
module tb_tawas_rcn_slave;
    localparam logic [23:0] BASE  = 24'h000000;
    localparam logic [23:0] MASK  = 24'hFF0000;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tawas_rcn_slave_if bus();

    tawas_rcn_slave #(
        .ADDR_BASE(BASE),
        .ADDR_MASK(MASK),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [68:0] pkt;
        int          c;
    } obs_t;

    typedef struct {
        logic [23:0] a;
        int          due;
    } pend_t;

    obs_t        outq[$];
    logic [60:0] csq[$];
    pend_t       pq[$];
    bit          resp_en = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rv_cyc  = -100;

    function automatic logic [31:0] rd_of(logic [23:0] a);
        if (a == 24'h000010) return 32'hCAFE_F00D;
        return {a[7:0], a} ^ 32'h5A0F_C3E1;
    endfunction

    function automatic logic [68:0] mk_req(logic w, logic [2:0] id,
        logic [4:0] sq, logic [3:0] m, logic [23:0] a, logic [31:0] d);
        return {1'b1, 1'b1, w, id, sq[4:2], m, a[23:2], sq[1:0], d};
    endfunction

    function automatic logic [68:0] mk_rsp(logic w, logic [2:0] id,
        logic [4:0] sq, logic [3:0] m, logic [23:0] a, logic [31:0] d);
        return {1'b1, 1'b0, w, id, sq[4:2], m, a[23:2], sq[1:0], d};
    endfunction

    // A write echoes its data; a read returns what local memory holds.
    function automatic logic [68:0] rsp_of(logic [68:0] q);
        logic [23:0] a;
        a = {q[55:34], 2'b00};
        return mk_rsp(q[66], q[65:63], {q[62:60], q[33:32]}, q[59:56], a,
                      q[66] ? q[31:0] : rd_of(a));
    endfunction

    function automatic int nsel(int base, bit is_req);
        int n = 0;
        for (int i = base; i < outq.size(); i++)
            if (outq[i].pkt[67] == is_req) n++;
        return n;
    endfunction

    function automatic obs_t getsel(int base, bit is_req, int k);
        obs_t r;
        int n = 0;
        r.pkt = '0;
        r.c   = -1;
        for (int i = base; i < outq.size(); i++) begin
            if (outq[i].pkt[67] == is_req) begin
                if (n == k) return outq[i];
                n++;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        #2;
        if (bus.rcn_out[68] === 1'b1) outq.push_back('{bus.rcn_out, cyc});
    end

    // Local memory: one rvalid per cs, in order, after a random latency.
    always @(posedge clk) begin
        #1;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        if (bus.cs === 1'b1) begin
            csq.push_back({bus.wr, bus.mask, bus.addr, bus.wdata});
`ifdef TAWAS_RCN_SLAVE_WR_POSTED_EN
            if (!bus.wr)
`endif
            pq.push_back('{bus.addr, cyc + int'($urandom_range(lat_max, lat_min))});
        end
        if (resp_en && pq.size() > 0 && pq[0].due <= cyc) begin
            bus.rvalid = 1'b1;
            bus.rdata  = rd_of(pq[0].a);
            rv_cyc     = cyc;
            void'(pq.pop_front());
        end
    end

    task automatic chk(string tag, logic [68:0] obs, logic [68:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [68:0] req;
        logic [68:0] q5[5];
        logic [68:0] exp_rsp[$];
        logic [68:0] exp_pass[$];
        logic [60:0] exp_cs[$];
        obs_t        r;
        int          ob;
        int          cb;
        int          idle;
        int          pushed;

        rst        = 1'b1;
        bus.rcn_in = '0;
        step(3);
        chk("rst_out", bus.rcn_out, 69'd0);
        chk("rst_cs", 69'(bus.cs), 69'd0);
        chk("rst_wr", 69'(bus.wr), 69'd0);
        chk("rst_mask", 69'(bus.mask), 69'd0);
        chk("rst_addr", 69'(bus.addr), 69'd0);
        chk("rst_wdata", 69'(bus.wdata), 69'd0);
        rst = 1'b0;
        step(2);

        // Read with rvalid two cycles after cs, idle ring.
        resp_en = 1'b1;
        lat_min = 2;
        lat_max = 2;
        ob = outq.size();
        cb = csq.size();
        req = mk_req(1'b0, 3'd3, 5'h0B, 4'hF, 24'h000010, 32'h0);
        bus.rcn_in = req;
        step();
        bus.rcn_in = '0;
        step();
        chk("rd_cs", 69'(bus.cs), 69'd1);
        chk("rd_wr", 69'(bus.wr), 69'd0);
        chk("rd_addr", 69'(bus.addr), 69'h000010);
        for (int t = 0; t < 30 && nsel(ob, 1'b0) < 1; t++) step();
        chk("rd_nrsp", 69'(nsel(ob, 1'b0)), 69'd1);
        r = getsel(ob, 1'b0, 0);
        chk("rd_pkt", r.pkt,
            mk_rsp(1'b0, 3'd3, 5'h0B, 4'hF, 24'h000010, 32'hCAFE_F00D));
        chk("rd_lat", 69'(r.c), 69'(rv_cyc + 2));
        chk("rd_ncs", 69'(csq.size() - cb), 69'd1);

        // Write: byte mask 3, data echoed in the response.
        ob = outq.size();
        req = mk_req(1'b1, 3'd5, 5'h11, 4'h3, 24'h000020, 32'h1234_5678);
        bus.rcn_in = req;
        step();
        bus.rcn_in = '0;
        step();
        chk("wr_cs", 69'(bus.cs), 69'd1);
        chk("wr_wr", 69'(bus.wr), 69'd1);
        chk("wr_mask", 69'(bus.mask), 69'h3);
        chk("wr_wdata", 69'(bus.wdata), 69'h1234_5678);
        for (int t = 0; t < 30 && nsel(ob, 1'b0) < 1; t++) step();
        chk("wr_pkt", getsel(ob, 1'b0, 0).pkt,
            mk_rsp(1'b1, 3'd5, 5'h11, 4'h3, 24'h000020, 32'h1234_5678));

        // Out-of-window request is a plain two-cycle hop.
        step(3);
        cb = csq.size();
        req = mk_req(1'b0, 3'd2, 5'h07, 4'hF, 24'h010000, 32'hDEAD_BEEF);
        bus.rcn_in = req;
        step();
        bus.rcn_in = '0;
        step();
        chk("oow_out", bus.rcn_out, req);
        chk("oow_cs", 69'(bus.cs), 69'd0);
        step(3);
        chk("oow_ncs", 69'(csq.size() - cb), 69'd0);

        // Queue full: five back-to-back, completions withheld.
        resp_en = 1'b0;
        lat_min = 1;
        lat_max = 1;
        ob = outq.size();
        cb = csq.size();
        for (int k = 0; k < 5; k++) begin
            q5[k] = mk_req(1'b0, 3'(k), 5'(k + 8), 4'hF,
                           24'h000100 + 24'(k * 4), 32'(k));
            bus.rcn_in = q5[k];
            step();
        end
        bus.rcn_in = '0;
        step(4);
        chk("full_ncs", 69'(csq.size() - cb), 69'd4);
        chk("full_npass", 69'(nsel(ob, 1'b1)), 69'd1);
        chk("full_pass", getsel(ob, 1'b1, 0).pkt, q5[4]);
        chk("full_nrsp0", 69'(nsel(ob, 1'b0)), 69'd0);
        resp_en = 1'b1;
        for (int t = 0; t < 60 && nsel(ob, 1'b0) < 4; t++) step();
        chk("full_nrsp", 69'(nsel(ob, 1'b0)), 69'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("full_rsp%0d", k), getsel(ob, 1'b0, k).pkt,
                rsp_of(q5[k]));

        // Busy ring: response waits for the first empty slot.
        step(3);
        ob = outq.size();
        req = mk_req(1'b0, 3'd6, 5'h1D, 4'hC, 24'h000040, 32'h0);
        bus.rcn_in = req;
        step();
        for (int i = 0; i < 12; i++) begin
            bus.rcn_in = mk_req(1'b0, 3'd1, 5'(i), 4'hF,
                                24'h020000 + 24'(i * 4), $urandom);
            step();
        end
        chk("busy_none", 69'(nsel(ob, 1'b0)), 69'd0);
        idle = cyc;
        bus.rcn_in = '0;
        step(3);
        chk("busy_nrsp", 69'(nsel(ob, 1'b0)), 69'd1);
        r = getsel(ob, 1'b0, 0);
        chk("busy_pkt", r.pkt, rsp_of(req));
        chk("busy_slot", 69'(r.c), 69'(idle + 2));

        // Reset with two reads outstanding; late completions ignored.
        step(3);
        resp_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.rcn_in = mk_req(1'b0, 3'(k), 5'(k), 4'hF,
                                24'h000200 + 24'(k * 4), 32'h0);
            step();
        end
        bus.rcn_in = '0;
        step(3);
        rst = 1'b1;
        step();
        ob = outq.size();
        chk("mid_rst_out", bus.rcn_out, 69'd0);
        chk("mid_rst_cs", 69'(bus.cs), 69'd0);
        rst = 1'b0;
        resp_en = 1'b1;
        step(12);
        chk("mid_rst_late", 69'(pq.size()), 69'd0);
        chk("mid_rst_nout", 69'(outq.size() - ob), 69'd0);

        // Random mixed traffic against the transaction model.
        lat_min = 1;
        lat_max = 4;
        ob = outq.size();
        cb = csq.size();
        pushed = 0;
        for (int n = 0; n < 40; n++) begin
            logic        w;
            logic [23:0] a;
            logic [31:0] d;
            logic [3:0]  m;
            logic [2:0]  id;
            logic [4:0]  sq;
            bit          inw;
            w   = 1'($urandom);
            m   = 4'($urandom);
            id  = 3'($urandom);
            sq  = 5'($urandom);
            d   = $urandom;
            inw = ($urandom_range(2, 0) != 0);
            if (inw)
                a = ((BASE & MASK) | (24'($urandom) & ~MASK)) & 24'hFFFFFC;
            else
                a = {8'($urandom_range(255, 1)), 16'($urandom)} & 24'hFFFFFC;
            req = mk_req(w, id, sq, m, a, d);
            if (inw) begin
                for (int t = 0; t < 200 && pushed - nsel(ob, 1'b0) >= DEPTH; t++)
                    step();
                exp_rsp.push_back(rsp_of(req));
                exp_cs.push_back({w, m, a, d});
                pushed++;
            end else begin
                exp_pass.push_back(req);
            end
            bus.rcn_in = req;
            step();
            bus.rcn_in = '0;
            repeat ($urandom_range(2, 0)) step();
        end
        for (int t = 0; t < 400 && (nsel(ob, 1'b0) < pushed || pq.size() > 0); t++)
            step();
        step(4);
        chk("rnd_nrsp", 69'(nsel(ob, 1'b0)), 69'(exp_rsp.size()));
        chk("rnd_npass", 69'(nsel(ob, 1'b1)), 69'(exp_pass.size()));
        chk("rnd_ncs", 69'(csq.size() - cb), 69'(exp_cs.size()));
        for (int k = 0; k < exp_rsp.size(); k++)
            chk($sformatf("rnd_rsp%0d", k), getsel(ob, 1'b0, k).pkt, exp_rsp[k]);
        for (int k = 0; k < exp_pass.size(); k++)
            chk($sformatf("rnd_pass%0d", k), getsel(ob, 1'b1, k).pkt, exp_pass[k]);
        for (int k = 0; k < exp_cs.size() && cb + k < csq.size(); k++)
            chk($sformatf("rnd_cs%0d", k), 69'(csq[cb + k]), 69'(exp_cs[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
